// File: rtl/regfile_scoreboard.sv
// Shadows both register-file writeback ports during a run, then sweeps the shadow against a preloaded
// expected table one register per cycle; results are held in DONE until the next start or reset.
module regfile_scoreboard #(
  parameter int          DATA_W  = 32,
  parameter int          NREGS   = 15,
  parameter int          ADDR_W  = 4,
  parameter int          CNT_W   = 16,
  parameter int          TIMEOUT = 2500,
  parameter logic [31:0] HALT_PC = 32'hFFFF_FFFC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              clear_exp,
  input  logic              exp_we,
  input  logic [ADDR_W-1:0] exp_addr,
  input  logic [DATA_W-1:0] exp_data,
  input  logic [31:0]       pc,
  input  logic [1:0]        we,
  input  logic [ADDR_W-1:0] wa3,
  input  logic [DATA_W-1:0] wd3,
  input  logic [ADDR_W-1:0] wa3_2,
  input  logic [DATA_W-1:0] wd3_2,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [CNT_W-1:0]  fail_count,
  output logic [ADDR_W-1:0] first_fail_idx,
  output logic [DATA_W-1:0] first_fail_got,
  output logic [DATA_W-1:0] first_fail_exp,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  write_count
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_CHECK, S_DONE} state_t;

  localparam logic [ADDR_W:0]   NREGS_V  = (ADDR_W+1)'(NREGS);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS-1);
  localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);
  localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(TIMEOUT-1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  state_t state, state_nxt;

  logic [DATA_W-1:0] shadow  [NREGS];
  logic [DATA_W-1:0] exp_tab [NREGS];
  logic [NREGS-1:0]  en;
  logic [ADDR_W-1:0] idx;

  logic             p1_ok, p2_ok, exp_ok, halt_hit, tmo_hit, chk_bad;
  logic [1:0]       nwr;
  logic [CNT_W:0]   wc_sum;
  logic [CNT_W-1:0] wc_next, cyc_next, fail_next;

  // Addresses at or above NREGS (R15/PC) are never tracked.
  assign p1_ok    = we[0] && ({1'b0, wa3} < NREGS_V);
  assign p2_ok    = we[1] && ({1'b0, wa3_2} < NREGS_V);
  assign exp_ok   = exp_we && ({1'b0, exp_addr} < NREGS_V);
  assign halt_hit = (pc == HALT_PC);
  assign tmo_hit  = (cycle_count == TMO_LAST);
  assign chk_bad  = en[idx] && (shadow[idx] != exp_tab[idx]);

  assign nwr       = {1'b0, p1_ok} + {1'b0, p2_ok};
  assign wc_sum    = {1'b0, write_count} + {{(CNT_W-1){1'b0}}, nwr};
  assign wc_next   = wc_sum[CNT_W] ? CNT_MAX : wc_sum[CNT_W-1:0];
  assign cyc_next  = (cycle_count == CNT_MAX) ? CNT_MAX : cycle_count + CNT_ONE;
  assign fail_next = (fail_count == CNT_MAX) ? CNT_MAX : fail_count + CNT_ONE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    pass      = 1'b0;
    unique case (state)
      S_IDLE: if (start) state_nxt = S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (halt_hit || tmo_hit) state_nxt = S_CHECK;
      end
      S_CHECK: begin
        busy = 1'b1;
        if (idx == LAST_IDX) state_nxt = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        pass = (fail_count == '0) && !timeout;
        if (start) state_nxt = S_RUN;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        shadow[i]  <= '0;
        exp_tab[i] <= '0;
      end
      en             <= '0;
      idx            <= '0;
      timeout        <= 1'b0;
      fail_count     <= '0;
      first_fail_idx <= '1;
      first_fail_got <= '0;
      first_fail_exp <= '0;
      cycle_count    <= '0;
      write_count    <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          // A load in the same cycle as clear_exp keeps its own enable bit.
          if (clear_exp) en <= '0;
          if (exp_ok) begin
            exp_tab[exp_addr] <= exp_data;
            en[exp_addr]      <= 1'b1;
          end
          if (start) begin
            for (int i = 0; i < NREGS; i++) shadow[i] <= '0;
            idx            <= '0;
            timeout        <= 1'b0;
            fail_count     <= '0;
            first_fail_idx <= '1;
            first_fail_got <= '0;
            first_fail_exp <= '0;
            cycle_count    <= '0;
            write_count    <= '0;
          end
        end
        S_RUN: begin
          cycle_count <= cyc_next;
          write_count <= wc_next;
          if (p1_ok) shadow[wa3] <= wd3;
          // Port 2 is written last so it wins on an address collision.
          if (p2_ok) shadow[wa3_2] <= wd3_2;
          if (tmo_hit) timeout <= 1'b1;
        end
        S_CHECK: begin
          idx <= idx + IDX_ONE;
          if (chk_bad) begin
            fail_count <= fail_next;
            if (fail_count == '0) begin
              first_fail_idx <= idx;
              first_fail_got <= shadow[idx];
              first_fail_exp <= exp_tab[idx];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed scenarios with literal expectations plus randomized runs,
// all compared every cycle against a run-level behavioural model.
module tb_regfile_scoreboard;

  localparam int          NR   = 15;
  localparam int          TMO  = 20;
  localparam logic [31:0] HALT = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        reset, start, clear_exp, exp_we;
  logic [3:0]  exp_addr, wa3, wa3_2;
  logic [31:0] exp_data, pc, wd3, wd3_2;
  logic [1:0]  we;
  logic        busy, done, pass, timeout;
  logic [15:0] fail_count, cycle_count, write_count;
  logic [3:0]  first_fail_idx;
  logic [31:0] first_fail_got, first_fail_exp;

  always #5 clk = ~clk;

  regfile_scoreboard #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .start(start), .clear_exp(clear_exp),
    .exp_we(exp_we), .exp_addr(exp_addr), .exp_data(exp_data), .pc(pc),
    .we(we), .wa3(wa3), .wd3(wd3), .wa3_2(wa3_2), .wd3_2(wd3_2),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .fail_count(fail_count), .first_fail_idx(first_fail_idx),
    .first_fail_got(first_fail_got), .first_fail_exp(first_fail_exp),
    .cycle_count(cycle_count), .write_count(write_count)
  );

  int checks = 0;
  int errors = 0;
  bit chk_on = 0;

  // Run-level model: phase 0 idle, 1 run, 2 check, 3 done.
  logic [31:0] m_exp [NR];
  logic [31:0] m_sh  [NR];
  bit          m_en  [NR];
  int          m_phase, m_cyc, m_wc, m_left, m_fails, m_first;
  logic [31:0] m_fgot, m_fexp;
  bit          m_tmo;

  task automatic check1(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic clear_results();
    m_cyc = 0; m_wc = 0; m_tmo = 0; m_fails = 0; m_first = -1; m_fgot = 0; m_fexp = 0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      m_exp[i] = 0; m_sh[i] = 0; m_en[i] = 0;
    end
    m_phase = 0; m_left = 0;
    clear_results();
  endtask

  task automatic model_step();
    case (m_phase)
      0, 3: begin
        if (clear_exp) for (int i = 0; i < NR; i++) m_en[i] = 0;
        if (exp_we && int'(exp_addr) < NR) begin
          m_exp[exp_addr] = exp_data;
          m_en[exp_addr]  = 1;
        end
        if (start) begin
          for (int i = 0; i < NR; i++) m_sh[i] = 0;
          clear_results();
          m_phase = 1;
        end
      end
      1: begin
        m_cyc++;
        if (we[0] && int'(wa3) < NR) begin m_sh[wa3] = wd3; m_wc++; end
        if (we[1] && int'(wa3_2) < NR) begin m_sh[wa3_2] = wd3_2; m_wc++; end
        if (m_cyc >= TMO) m_tmo = 1;
        if (pc == HALT || m_cyc >= TMO) begin
          m_phase = 2;
          m_left  = NR;
        end
      end
      2: begin
        m_left--;
        if (m_left == 0) begin
          m_phase = 3;
          for (int i = 0; i < NR; i++) begin
            if (m_en[i] && m_sh[i] != m_exp[i]) begin
              if (m_fails == 0) begin
                m_first = i; m_fgot = m_sh[i]; m_fexp = m_exp[i];
              end
              m_fails++;
            end
          end
        end
      end
      default: ;
    endcase
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check1("busy", busy, (m_phase == 1 || m_phase == 2));
      check1("done", done, (m_phase == 3));
      check1("pass", pass, (m_phase == 3 && m_fails == 0 && !m_tmo));
      check1("timeout", timeout, m_tmo);
      check1("cycle_count", cycle_count, m_cyc);
      check1("write_count", write_count, m_wc);
      if (m_phase != 2) begin
        check1("fail_count", fail_count, m_fails);
        check1("first_fail_idx", first_fail_idx, (m_first < 0) ? 32'd15 : m_first);
        check1("first_fail_got", first_fail_got, m_fgot);
        check1("first_fail_exp", first_fail_exp, m_fexp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    start = 0; clear_exp = 0; exp_we = 0; we = 2'b00; pc = 32'h0;
  endtask

  task automatic load(input logic clr, input logic [3:0] a, input logic [31:0] d);
    clear_exp = clr; exp_we = 1; exp_addr = a; exp_data = d;
    tick();
  endtask

  task automatic wr(input logic [1:0] w, input logic [3:0] a1, input logic [31:0] d1,
                    input logic [3:0] a2, input logic [31:0] d2);
    we = w; wa3 = a1; wd3 = d1; wa3_2 = a2; wd3_2 = d2;
    tick();
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 80) begin
      tick();
      n++;
    end
    check1("wait_done", done, 1'b1);
  endtask

  int n;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; start = 0; clear_exp = 0; exp_we = 0; exp_addr = 0; exp_data = 0;
    pc = 0; we = 0; wa3 = 0; wd3 = 0; wa3_2 = 0; wd3_2 = 0;
    model_reset();
    #2;
    check1("rst_busy", busy, 1'b0);
    check1("rst_done", done, 1'b0);
    check1("rst_pass", pass, 1'b0);
    check1("rst_ffidx", first_fail_idx, 32'hF);
    check1("rst_cycles", cycle_count, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 0;
    chk_on = 1;

    // Single write, normal halt; check sweep takes one cycle per register.
    load(0, 4'd0, 32'd10);
    start = 1; tick();
    wr(2'b01, 4'd0, 32'd10, 4'd0, 32'd0);
    pc = HALT; tick();
    wait_done(n);
    check1("t1_check_len", n, 32'd15);
    check1("t1_pass", pass, 1'b1);
    check1("t1_fails", fail_count, 32'd0);
    check1("t1_writes", write_count, 32'd1);
    check1("t1_cycles", cycle_count, 32'd2);

    // One mismatch on R3.
    load(1, 4'd0, 32'd10);
    load(0, 4'd3, 32'd7);
    start = 1; tick();
    wr(2'b11, 4'd0, 32'd10, 4'd3, 32'd9);
    pc = HALT; tick();
    wait_done(n);
    check1("t2_pass", pass, 1'b0);
    check1("t2_fails", fail_count, 32'd1);
    check1("t2_idx", first_fail_idx, 32'd3);
    check1("t2_got", first_fail_got, 32'd9);
    check1("t2_exp", first_fail_exp, 32'd7);

    // Same-address collision (port 2 wins), then long-multiply pair.
    load(1, 4'd2, 32'd6);
    load(0, 4'd4, 32'd1);
    load(0, 4'd5, 32'hFFFF_FFFF);
    start = 1; tick();
    wr(2'b11, 4'd2, 32'd5, 4'd2, 32'd6);
    check1("t3_writes_mid", write_count, 32'd2);
    wr(2'b11, 4'd4, 32'd1, 4'd5, 32'hFFFF_FFFF);
    pc = HALT; tick();
    wait_done(n);
    check1("t3_pass", pass, 1'b1);
    check1("t3_writes", write_count, 32'd4);
    check1("t3_fails", fail_count, 32'd0);

    // Watchdog: no halt, everything matches, still fails.
    load(1, 4'd0, 32'd0);
    start = 1; tick();
    wait_done(n);
    check1("t4_len", n, 32'd35);
    check1("t4_cycles", cycle_count, 32'd20);
    check1("t4_timeout", timeout, 1'b1);
    check1("t4_pass", pass, 1'b0);

    // R15 is ignored both as a write target and an expected entry.
    load(1, 4'd15, 32'd99);
    start = 1; tick();
    wr(2'b01, 4'd15, 32'd5, 4'd0, 32'd0);
    pc = HALT; tick();
    wait_done(n);
    check1("t5_writes", write_count, 32'd0);
    check1("t5_pass", pass, 1'b1);

    // Reset mid-run drops everything asynchronously and wipes the expected table.
    load(0, 4'd1, 32'd123);
    start = 1; tick();
    wr(2'b01, 4'd1, 32'd5, 4'd0, 32'd0);
    repeat (4) tick();
    #2 reset = 1;
    #1;
    check1("t6_busy", busy, 1'b0);
    check1("t6_done", done, 1'b0);
    check1("t6_cycles", cycle_count, 32'd0);
    check1("t6_writes", write_count, 32'd0);
    check1("t6_ffidx", first_fail_idx, 32'hF);
    model_reset();
    @(posedge clk);
    #1 reset = 0;
    start = 1; tick();
    wr(2'b01, 4'd1, 32'd5, 4'd0, 32'd0);
    pc = HALT; tick();
    wait_done(n);
    check1("t6_pass", pass, 1'b1);
    check1("t6_fails", fail_count, 32'd0);

    // Randomized runs, including ignored start/load noise during RUN and CHECK.
    for (int r = 0; r < 30; r++) begin
      repeat ($urandom_range(0, 5)) begin
        clear_exp = ($urandom_range(0, 5) == 0);
        exp_we    = ($urandom_range(0, 3) != 0);
        exp_addr  = 4'($urandom_range(0, 15));
        exp_data  = $urandom_range(0, 3);
        tick();
      end
      start = 1; tick();
      for (int c = 0; c < 60 && m_phase != 3; c++) begin
        pc        = ($urandom_range(0, 11) == 0) ? HALT : $urandom;
        we        = 2'($urandom_range(0, 3));
        wa3       = 4'($urandom_range(0, 15));
        wa3_2     = 4'($urandom_range(0, 15));
        wd3       = $urandom_range(0, 3);
        wd3_2     = $urandom_range(0, 3);
        start     = ($urandom_range(0, 9) == 0);
        exp_we    = ($urandom_range(0, 7) == 0);
        clear_exp = ($urandom_range(0, 7) == 0);
        exp_addr  = 4'($urandom_range(0, 15));
        exp_data  = $urandom_range(0, 3);
        tick();
      end
      check1("rnd_done", done, 1'b1);
    end

    chk_on = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
